// File: rtl/ifetch_unit.sv
// ifetch_unit
//   Instruction fetch front end for the ad100 CPU. Owns the fetch PC, issues
//   one word request at a time to instruction memory, queues returned words
//   together with their byte PC, and hands them to decode over a valid/ready
//   handshake. Redirects from the CPU flush the queue and retarget fetch; a
//   response still in flight at redirect time is absorbed and thrown away.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   imem_req/addr     one-cycle request strobe and word address to memory
//   imem_valid/rdata  response strobe and instruction word from memory
//   inst_valid/inst/inst_pc/inst_ready   queue head presented to the CPU
//   redirect_valid/redirect_pc           new fetch target from the CPU
//   fetch_misaligned  sticky fault: last redirect target not word aligned
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_misaligned
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [29:0]      addr_q, addr_d;
    logic [31:0]      tag_q, tag_d;
    logic             outstanding_q, outstanding_d;
    logic             discard_q, discard_d;
    logic             misaligned_q, misaligned_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [31:0]      q_inst_q [DEPTH];
    logic [31:0]      q_pc_q   [DEPTH];

    logic issue;
    logic resp;
    logic push;
    logic pop;
    logic full;

    always_comb begin
        full = (count_q == CNT_W'(DEPTH));
        // Issue is decided and presented in the same cycle. Reset is folded in
        // so the strobe stays low while reset is held.
        issue = !reset && !outstanding_q && !full && !misaligned_q && !redirect_valid;
        resp  = imem_valid && outstanding_q;
        // A redirect wins over any push or pop in its cycle.
        push  = resp && !discard_q && !redirect_valid;
        pop   = (count_q != '0) && inst_ready && !redirect_valid;

        fetch_pc_d    = fetch_pc_q;
        addr_d        = addr_q;
        tag_d         = tag_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        misaligned_d  = misaligned_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;

        if (resp) begin
            outstanding_d = 1'b0;
            discard_d     = 1'b0;
        end

        if (issue) begin
            outstanding_d = 1'b1;
            tag_d         = fetch_pc_q;
            addr_d        = fetch_pc_q[31:2];
            fetch_pc_d    = fetch_pc_q + 32'd4;
        end

        if (push) tail_d = tail_q + PTR_W'(1);
        if (pop)  head_d = head_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (redirect_valid) begin
            head_d       = '0;
            tail_d       = '0;
            count_d      = '0;
            fetch_pc_d   = redirect_pc;
            misaligned_d = (redirect_pc[1:0] != 2'b00);
            // A word arriving in the redirect cycle is dropped by the flush
            // above; one still in flight must be swallowed when it lands.
            if (outstanding_q && !imem_valid) discard_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            addr_q        <= RESET_PC[31:2];
            tag_q         <= '0;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            misaligned_q  <= 1'b0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            addr_q        <= addr_d;
            tag_q         <= tag_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            misaligned_q  <= misaligned_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
        end
    end

    // Queue storage: each entry loads when it is the tail and a push happens.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                q_inst_q[gi] <= '0;
                q_pc_q[gi]   <= '0;
            end else if (push && (tail_q == PTR_W'(gi))) begin
                q_inst_q[gi] <= imem_rdata;
                q_pc_q[gi]   <= tag_q;
            end
        end
    end

    assign imem_req         = issue;
    assign imem_addr        = issue ? fetch_pc_q[31:2] : addr_q;
    assign inst_valid       = (count_q != '0);
    assign inst             = q_inst_q[head_q];
    assign inst_pc          = q_pc_q[head_q];
    assign fetch_misaligned = misaligned_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Testbench for ifetch_unit: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
// A second instance with RESET_PC=32'hFFFFFFFC covers PC wraparound.
module tb_ifetch_unit;
    localparam int DEPTH = 2;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_misaligned;

    logic        w_imem_req;
    logic [29:0] w_imem_addr;
    logic        w_imem_valid;
    logic [31:0] w_imem_rdata;
    logic        w_inst_valid;
    logic [31:0] w_inst;
    logic [31:0] w_inst_pc;
    logic        w_inst_ready;
    logic        w_redirect_valid;
    logic [31:0] w_redirect_pc;
    logic        w_fetch_misaligned;

    ifetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_misaligned(fetch_misaligned)
    );

    ifetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)) dut_w (
        .clk(clk), .reset(reset),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_valid(w_imem_valid), .imem_rdata(w_imem_rdata),
        .inst_valid(w_inst_valid), .inst(w_inst), .inst_pc(w_inst_pc),
        .inst_ready(w_inst_ready),
        .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
        .fetch_misaligned(w_fetch_misaligned)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int stray_cyc = -1;
    int mem_lat  = 1;
    bit stray_en = 0;
    bit verbose  = 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        if (a == 30'd0) return 32'h0000_0013;
        if (a == 30'd1) return 32'h0080_00EF;
        return {a, 2'b11} ^ 32'h5A5A_0000;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory for the main instance ----------------
    int          due_q[$];
    logic [31:0] dat_q[$];

    always @(negedge clk) begin
        if (!reset && imem_req) begin
            due_q.push_back(cyc + ((mem_lat != 0) ? mem_lat : int'($urandom_range(1, 4))));
            dat_q.push_back(mem_word(imem_addr));
        end
    end

    always @(posedge clk) begin
        #1;
        if (reset) begin
            due_q.delete();
            dat_q.delete();
        end
        if (due_q.size() != 0 && due_q[0] == cyc) begin
            imem_valid = 1'b1;
            imem_rdata = dat_q[0];
            void'(due_q.pop_front());
            void'(dat_q.pop_front());
        end else if (cyc == stray_cyc) begin
            imem_valid = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
        end else if (stray_en && due_q.size() == 0 && ($urandom % 16) == 0) begin
            imem_valid = 1'b1;
            imem_rdata = $urandom;
        end else begin
            imem_valid = 1'b0;
            imem_rdata = $urandom;
        end
    end

    // ---------------- memory for the wraparound instance ----------------
    bit          w_pend = 0;
    int          w_due  = 0;
    logic [31:0] w_dat  = '0;

    always @(negedge clk) begin
        if (!reset && w_imem_req) begin
            w_pend = 1;
            w_due  = cyc + 1;
            w_dat  = {w_imem_addr, 2'b00} ^ 32'h1234_0000;
        end
    end

    always @(posedge clk) begin
        #1;
        if (reset) w_pend = 0;
        if (w_pend && w_due == cyc) begin
            w_imem_valid = 1'b1;
            w_imem_rdata = w_dat;
            w_pend = 0;
        end else begin
            w_imem_valid = 1'b0;
            w_imem_rdata = '0;
        end
    end

    // ---------------- behavioural model ----------------
    // Queue of {inst, pc}; state described in terms of the fetch rules.
    logic [63:0] m_q[$];
    logic [31:0] m_fpc  = 32'h0;
    logic [29:0] m_addr = 30'h0;
    logic [31:0] m_tag  = 32'h0;
    bit          m_out  = 0;
    bit          m_disc = 0;
    bit          m_mis  = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_fpc  = 32'h0;
            m_addr = 30'h0;
            m_out  = 0;
            m_disc = 0;
            m_mis  = 0;
        end else if (redirect_valid) begin
            m_q.delete();
            m_fpc = redirect_pc;
            m_mis = (redirect_pc[1:0] != 2'b00);
            if (m_out) begin
                if (imem_valid) begin
                    m_out  = 0;
                    m_disc = 0;
                end else begin
                    m_disc = 1;
                end
            end
        end else begin
            bit req;
            req = !m_out && (m_q.size() < DEPTH) && !m_mis;
            if (m_q.size() != 0 && inst_ready) void'(m_q.pop_front());
            if (imem_valid && m_out) begin
                m_out = 0;
                if (m_disc) m_disc = 0;
                else m_q.push_back({imem_rdata, m_tag});
            end
            if (req) begin
                m_out  = 1;
                m_tag  = m_fpc;
                m_addr = m_fpc[31:2];
                m_fpc  = m_fpc + 32'd4;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_req", imem_req, 0);
            chk("rst_addr", imem_addr, 0);
            chk("rst_valid", inst_valid, 0);
            chk("rst_inst", {inst, inst_pc}, 0);
            chk("rst_misaligned", fetch_misaligned, 0);
        end else begin
            bit exp_req;
            exp_req = !m_out && (m_q.size() < DEPTH) && !m_mis && !redirect_valid;
            chk("req", imem_req, exp_req);
            chk("addr", imem_addr, exp_req ? m_fpc[31:2] : m_addr);
            chk("valid", inst_valid, m_q.size() != 0);
            if (m_q.size() != 0) chk("head", {inst, inst_pc}, m_q[0]);
            chk("misaligned", fetch_misaligned, m_mis);
        end
    end

    // ---------------- event logs for literal checks ----------------
    logic [29:0] req_log[$];
    logic [63:0] pop_log[$];
    logic [29:0] w_req_log[$];
    logic [63:0] w_pop_log[$];

    always @(negedge clk) begin
        if (reset) begin
            w_req_log.delete();
            w_pop_log.delete();
        end else begin
            if (imem_req) req_log.push_back(imem_addr);
            if (inst_valid && inst_ready && !redirect_valid) begin
                pop_log.push_back({inst, inst_pc});
                if (verbose) $display("pop   pc=%h inst=%h", inst_pc, inst);
            end
            if (w_imem_req) w_req_log.push_back(w_imem_addr);
            if (w_inst_valid) w_pop_log.push_back({w_inst, w_inst_pc});
        end
    end

    function automatic logic [63:0] req_at(input int i);
        return (i < req_log.size()) ? 64'(req_log[i]) : '1;
    endfunction
    function automatic logic [63:0] pop_at(input int i);
        return (i < pop_log.size()) ? pop_log[i] : '1;
    endfunction

    task automatic clear_logs();
        req_log.delete();
        pop_log.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Waits at negedges for a request (to a given word address unless any=1).
    task automatic wait_req(input string name, input logic [29:0] a, input bit any, input int lim);
        bit found;
        found = 0;
        for (int k = 0; k < lim && !found; k++) begin
            @(negedge clk);
            if (imem_req && (any || imem_addr == a)) found = 1;
        end
        chk(name, found, 1);
    endtask

    initial begin
        reset          = 1'b1;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_valid     = 1'b0;
        imem_rdata     = '0;
        w_inst_ready   = 1'b1;
        w_redirect_valid = 1'b0;
        w_redirect_pc  = '0;
        w_imem_valid   = 1'b0;
        w_imem_rdata   = '0;

        // 1: basic fetch, 1-cycle memory, CPU always ready
        tick(3);
        reset = 1'b0;
        clear_logs();
        tick(8);
        $display("check basic fetch");
        chk("t1_addr0", req_at(0), 64'd0);
        chk("t1_addr1", req_at(1), 64'd1);
        chk("t1_pop0", pop_at(0), {32'h0000_0013, 32'h0000_0000});
        chk("t1_pop1", pop_at(1), {32'h0080_00EF, 32'h0000_0004});
        chk("wrap_addr0", (w_req_log.size() > 0) ? 64'(w_req_log[0]) : '1, 64'h3FFF_FFFF);
        chk("wrap_addr1", (w_req_log.size() > 1) ? 64'(w_req_log[1]) : '1, 64'h0);
        chk("wrap_pop0", (w_pop_log.size() > 0) ? w_pop_log[0] : '1, {32'hEDCB_FFFC, 32'hFFFF_FFFC});
        chk("wrap_pop1", (w_pop_log.size() > 1) ? w_pop_log[1] : '1, {32'h1234_0000, 32'h0000_0000});

        // 2: back-pressure fills exactly DEPTH entries
        reset = 1'b1;
        inst_ready = 1'b0;
        tick(2);
        reset = 1'b0;
        clear_logs();
        tick(20);
        $display("check back-pressure");
        chk("t2_nreq", req_log.size(), DEPTH);
        chk("t2_addr1", req_at(1), 64'd1);
        chk("t2_head", {inst_valid, inst_pc}, {1'b1, 32'h0});
        mem_lat = 3;
        clear_logs();
        inst_ready = 1'b1;
        wait_req("t2_resume_addr2", 30'd2, 0, 20);

        // 3: redirect while byte 8 is outstanding
        tick(1);
        chk("t2_pop_order", {pop_at(0), pop_at(1)},
            {32'h0000_0013, 32'h0000_0000, 32'h0080_00EF, 32'h0000_0004});
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0010;
        clear_logs();
        tick(1);
        redirect_valid = 1'b0;
        tick(14);
        $display("check redirect with discard");
        chk("t3_addr", req_at(0), 64'd4);
        chk("t3_pop_pc", pop_at(0) & 64'hFFFF_FFFF, 64'h10);
        for (int k = 0; k < pop_log.size(); k++)
            if (pop_log[k][31:0] == 32'h8) chk("t3_stale_pc", pop_log[k], '0);

        // 4: misaligned redirect and recovery
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0022;
        tick(1);
        redirect_valid = 1'b0;
        clear_logs();
        tick(10);
        $display("check misaligned redirect");
        chk("t4_fault", {fetch_misaligned, inst_valid}, 2'b10);
        chk("t4_nreq", req_log.size(), 0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        clear_logs();
        tick(1);
        redirect_valid = 1'b0;
        tick(10);
        chk("t4_clear", fetch_misaligned, 0);
        chk("t4_addr", req_at(0), 64'h10);

        // 5: reset with a request in flight, stray response right after release
        wait_req("t5_req", '0, 1, 20);
        tick(1);
        reset = 1'b1;
        mem_lat = 1;
        tick(2);
        stray_cyc = cyc + 1;
        tick(1);
        reset = 1'b0;
        clear_logs();
        tick(8);
        $display("check reset with stray response");
        chk("t5_addr", req_at(0), 64'd0);
        chk("t5_pop", pop_at(0), {32'h0000_0013, 32'h0000_0000});

        // 6: randomized traffic, redirects, strays and occasional reset
        verbose  = 0;
        stray_en = 1;
        mem_lat  = 0;
        for (int i = 0; i < 3000; i++) begin
            int r;
            @(posedge clk);
            #1;
            reset          = (i % 1000 == 500);
            inst_ready     = ($urandom % 4) != 0;
            redirect_valid = ($urandom % 20) == 0;
            r = int'($urandom % 8);
            if (r == 0)      redirect_pc = $urandom;
            else if (r == 1) redirect_pc = 32'hFFFF_FFF8;
            else             redirect_pc = $urandom_range(0, 63) << 2;
        end
        reset          = 1'b0;
        redirect_valid = 1'b0;
        tick(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch front end that sits directly upstream of the ad100 CPU decode/execute stage.
- Owns the fetch PC and drives word addresses to instruction memory.
- Buffers returned instruction words in a small queue and presents them to the CPU with a valid/ready handshake.
- Accepts redirects from the CPU (jal, jalr, taken branch) and flushes stale fetches.

Parameters:
- RESET_PC, 32'h00000000, byte address of the first fetch after reset; bits [1:0] must be 0.
- DEPTH, 2, instruction queue entries (power of two, ≥2).

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_req  output  1  one-cycle request strobe to instruction memory.
- imem_addr  output  30  word address (byte address >> 2) of the request.
- imem_valid  input  1  response strobe; earliest is the cycle after imem_req.
- imem_rdata  input  32  instruction word, valid with imem_valid.
- inst_valid  output  1  queue head holds an instruction.
- inst  output  32  queue head instruction.
- inst_pc  output  32  byte PC of the queue head.
- inst_ready  input  1  CPU consumes the head when inst_valid && inst_ready.
- redirect_valid  input  1  one-cycle strobe requesting a new fetch PC.
- redirect_pc  input  32  target byte address.
- fetch_misaligned  output  1  sticky fault: redirect target not word aligned.

Behaviour:
- Timing and reset:
  - One clock. Reset is asynchronous and active-high.
  - On reset: fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC[31:2], queue count=0, inst_valid=0, inst=0, inst_pc=0, fetch_misaligned=0, outstanding=0, discard=0.
- Request issue:
  - At most one outstanding request.
  - Issue in cycle N when all hold: !outstanding, count<DEPTH, !fetch_misaligned, no redirect_valid in N.
  - On issue: imem_req=1 for exactly one cycle, imem_addr=fetch_pc[31:2], outstanding←1, the pc tag is latched, fetch_pc←fetch_pc+4 (mod 2^32; wraps 32'hFFFFFFFC→0).
  - imem_addr holds its last value while imem_req=0.
- Response:
  - imem_valid with outstanding=1: outstanding←0. If discard=1, drop the word and clear discard. Otherwise push {imem_rdata, tag} to the tail.
  - imem_valid with outstanding=0 is ignored.
  - Response-to-issue spacing is ≥1 cycle, so peak throughput is 1 instruction per 2 cycles.
- Queue:
  - Circular buffer with wrapping head/tail pointers. inst/inst_pc come combinationally from the head entry.
  - Pop on inst_valid && inst_ready.
  - Push and pop in the same cycle: count unchanged.
  - Push cannot occur when full, because issue is gated on count<DEPTH, which guarantees space.
  - inst_valid=(count≠0).
- Redirect (priority over everything in that cycle):
  - Flush the queue; a concurrent pop or push is discarded.
  - fetch_pc←redirect_pc.
  - If outstanding=1 and imem_valid is not present this cycle, discard←1. If imem_valid is present this cycle, the word is simply dropped.
  - A second redirect while discard=1 only updates fetch_pc.
  - Fetch at the new PC starts once outstanding=0: the cycle after the redirect, or the cycle after the discarded response arrives.
  - A redirect in cycle N never allows imem_req in cycle N.
- Misaligned redirect:
  - redirect_pc[1:0]≠0 sets fetch_misaligned=1, flushes the queue, and stops new issues.
  - An outstanding response is still absorbed and discarded.
  - Only a later aligned redirect or reset clears the fault.
- Reset mid-operation clears all state immediately; any in-flight memory response after reset deasserts is ignored because outstanding=0.

Test Plan:
- Reset, memory with 1-cycle latency returning 32'h00000013 for word 0 and 32'h008000EF for word 1, inst_ready=1:
  - required: imem_addr=0 then 1; inst_pc=0 then 4; inst=00000013 then 008000EF.
- inst_ready=0 for 20 cycles:
  - required: exactly DEPTH=2 requests issued and held at inst_pc=0,4.
  - after raising ready: pops in order, fetch resumes at addr 2 (byte 8).
- Redirect to 32'h00000010 while the request for byte 8 is outstanding, response delayed 3 cycles:
  - required: the byte 8 word is never presented; next imem_addr=4; inst_pc=10.
- Redirect to 32'h00000022:
  - required: fetch_misaligned=1, inst_valid=0, no imem_req.
  - aligned redirect to 32'h40: fault clears, imem_addr=10h.
- RESET_PC=32'hFFFFFFFC:
  - required: first inst_pc=FFFFFFFC, next imem_addr=0, inst_pc=0.
- Assert reset while outstanding, then a stray imem_valid after release:
  - required: stray response ignored; first inst has inst_pc=RESET_PC.
